// File: rtl/gs_pkg.sv
// Shared constants and types for the gs instruction-memory responder.
// Optional parity support is enabled by defining GS_IMEM_PARITY_EN.
package gs_pkg;

   localparam logic [31:0] GS_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IMEM_LOAD  = 2'd0,
      IMEM_DRAIN = 2'd1,
      IMEM_RUN   = 2'd2
   } imem_state_e;

endpackage

// File: rtl/gs_imem_array.sv
// Single-port synchronous instruction RAM with registered read data.
// GS_IMEM_PARITY_EN adds one stored even-parity bit per word.
module gs_imem_array
   import gs_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [WORD_SIZE-1:0]     i_wdata,
`ifdef GS_IMEM_PARITY_EN
   input  logic                     i_wpar,
   output logic                     o_rpar,
`endif
   output logic [WORD_SIZE-1:0]     o_rdata
);

   logic [WORD_SIZE-1:0] r_mem [DEPTH];
   logic [WORD_SIZE-1:0] r_rdata;

   // Read-before-write on the shared port; reads during load are never consumed.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

`ifdef GS_IMEM_PARITY_EN
   logic r_par [DEPTH];
   logic r_rpar;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_par[i_addr] <= i_wpar;
      end
      r_rpar <= r_par[i_addr];
   end

   assign o_rpar = r_rpar;
`endif

endmodule

// File: rtl/gs_imem_responder.sv
// Instruction-memory responder: boot-time load phase, then fixed-latency fetch service.
// Defining GS_IMEM_PARITY_EN adds per-word parity checking and the par_err_cnt_o port.
module gs_imem_responder
   import gs_pkg::*;
#(
   parameter int unsigned          ADDR_SIZE = 32,
   parameter int unsigned          WORD_SIZE = 32,
   parameter int unsigned          DEPTH     = 1024,
   parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
   parameter int unsigned          LATENCY   = 1,
   parameter bit                   PRELOADED = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_SIZE-1:0] instr_addr_i,
   output logic [WORD_SIZE-1:0] instr_data_o,
   output logic                 fetch_err_o,
   input  logic                 ld_valid_i,
   output logic                 ld_ready_o,
   input  logic [ADDR_SIZE-1:0] ld_addr_i,
   input  logic [WORD_SIZE-1:0] ld_data_i,
   input  logic                 ld_done_i,
   output logic [15:0]          ld_cnt_o,
`ifdef GS_IMEM_PARITY_EN
   output logic [7:0]           par_err_cnt_o,
`endif
   output logic                 boot_done_o
);

   localparam int unsigned          AW          = $clog2(DEPTH);
   localparam logic [WORD_SIZE-1:0] NOP         = WORD_SIZE'(GS_NOP_INSTR);
   localparam imem_state_e          RESET_STATE = PRELOADED ? IMEM_RUN : IMEM_LOAD;

   imem_state_e          r_state, w_state_d;
   logic [1:0]           r_drain_cnt, w_drain_cnt_d;
   logic [15:0]          r_ld_cnt;

   logic [ADDR_SIZE-1:0] w_f_off, w_ld_off;
   logic [AW-1:0]        w_f_idx, w_ld_idx, w_ram_addr;
   logic                 w_f_bad, w_ld_bad, w_ld_fire, w_we;

   logic                 r_s1_use_mem, r_s1_err;
   logic [WORD_SIZE-1:0] w_rd_data, w_s1_data;
   logic                 w_s1_err, w_par_err;

   // Address decode: offset wraps at ADDR_SIZE bits, so addresses below BASE_ADDR land out of range.
   assign w_f_off  = instr_addr_i - BASE_ADDR;
   assign w_ld_off = ld_addr_i - BASE_ADDR;
   assign w_f_idx  = w_f_off[AW+1:2];
   assign w_ld_idx = w_ld_off[AW+1:2];
   assign w_f_bad  = (w_f_off[1:0] != 2'b00) || ((w_f_off >> 2) >= ADDR_SIZE'(DEPTH));
   assign w_ld_bad = (w_ld_off[1:0] != 2'b00) || ((w_ld_off >> 2) >= ADDR_SIZE'(DEPTH));

   assign ld_ready_o = (r_state == IMEM_LOAD) & ~rst;
   assign w_ld_fire  = ld_valid_i & ld_ready_o;
   assign w_we       = w_ld_fire & ~w_ld_bad;
   assign w_ram_addr = w_we ? w_ld_idx : w_f_idx;

   always_comb begin
      w_state_d     = r_state;
      w_drain_cnt_d = r_drain_cnt;
      case (r_state)
         IMEM_LOAD: begin
            if (ld_done_i) begin
               w_state_d     = IMEM_DRAIN;
               w_drain_cnt_d = 2'd0;
            end
         end
         IMEM_DRAIN: begin
            // Hold off RUN until the pipe has been flushed with LATENCY NOPs.
            if (r_drain_cnt == 2'(LATENCY - 1)) begin
               w_state_d = IMEM_RUN;
            end else begin
               w_drain_cnt_d = r_drain_cnt + 2'd1;
            end
         end
         IMEM_RUN: begin
            w_state_d = IMEM_RUN;
         end
         default: begin
            w_state_d = RESET_STATE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RESET_STATE;
         r_drain_cnt <= 2'd0;
         r_ld_cnt    <= 16'd0;
      end else begin
         r_state     <= w_state_d;
         r_drain_cnt <= w_drain_cnt_d;
         if (w_we && (r_ld_cnt != 16'hFFFF)) begin
            r_ld_cnt <= r_ld_cnt + 16'd1;
         end
      end
   end

   assign ld_cnt_o    = r_ld_cnt;
   assign boot_done_o = (r_state == IMEM_RUN);

   // First pipe stage travels alongside the RAM's own read register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_use_mem <= 1'b0;
         r_s1_err     <= 1'b0;
      end else begin
         r_s1_use_mem <= (r_state == IMEM_RUN) & ~w_f_bad;
         r_s1_err     <= (r_state == IMEM_RUN) & w_f_bad;
      end
   end

`ifdef GS_IMEM_PARITY_EN
   logic       w_rd_par;
   logic       w_wpar;
   logic [7:0] r_par_err_cnt;

   assign w_wpar    = ^ld_data_i;
   assign w_par_err = r_s1_use_mem & ((^w_rd_data) != w_rd_par);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par_err_cnt <= 8'd0;
      end else if (w_par_err && (r_par_err_cnt != 8'hFF)) begin
         r_par_err_cnt <= r_par_err_cnt + 8'd1;
      end
   end

   assign par_err_cnt_o = r_par_err_cnt;

   gs_imem_array #(
      .WORD_SIZE (WORD_SIZE),
      .DEPTH     (DEPTH)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_ram_addr),
      .i_wdata (ld_data_i),
      .i_wpar  (w_wpar),
      .o_rpar  (w_rd_par),
      .o_rdata (w_rd_data)
   );
`else
   assign w_par_err = 1'b0;

   gs_imem_array #(
      .WORD_SIZE (WORD_SIZE),
      .DEPTH     (DEPTH)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_ram_addr),
      .i_wdata (ld_data_i),
      .o_rdata (w_rd_data)
   );
`endif

   assign w_s1_data = (r_s1_use_mem & ~w_par_err) ? w_rd_data : NOP;
   assign w_s1_err  = r_s1_err | w_par_err;

   generate
      if (LATENCY > 1) begin : g_pipe
         logic [WORD_SIZE-1:0] r_data [LATENCY-1];
         logic                 r_err  [LATENCY-1];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                  r_data[i] <= NOP;
                  r_err[i]  <= 1'b0;
               end
            end else begin
               r_data[0] <= w_s1_data;
               r_err[0]  <= w_s1_err;
               for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                  r_data[i] <= r_data[i-1];
                  r_err[i]  <= r_err[i-1];
               end
            end
         end

         assign instr_data_o = r_data[LATENCY-2];
         assign fetch_err_o  = r_err[LATENCY-2];
      end else begin : g_nopipe
         assign instr_data_o = w_s1_data;
         assign fetch_err_o  = w_s1_err;
      end
   endgenerate

endmodule
